// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// datapath mux selects and ALU control codes.
package multicycle_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      LUI      = 4'd11,
      AUIPC    = 4'd12
   } stateT;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   function automatic logic [2:0] immSrcFor(input logic [6:0] op);
      case (op)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_JAL:           return IMM_J;
         OP_LUI, OP_AUIPC: return IMM_U;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU-op class plus funct fields to
// the ALU control code.
module alu_decoder
   import multicycle_pkg::*;
(
   input  logic [1:0] aluOp,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] aluControl
);

   always_comb begin
      aluControl = ALU_ADD;
      case (aluOp)
         ALUOP_SUB: aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // addi never subtracts: only R-type (op5=1) honours funct7b5
               3'b000:  aluControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  aluControl = ALU_SLT;
               3'b110:  aluControl = ALU_OR;
               3'b111:  aluControl = ALU_AND;
               default: aluControl = ALU_ADD;
            endcase
         end
         default: aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM for the shared-memory multi-cycle RV32I datapath: sequences fetch,
// decode, execute, memory and write-back, stalling on mem_ready.
module multicycle_controller
   import multicycle_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic [2:0] alu_control,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   stateT      state;
   logic       illegalOp;
   logic [1:0] aluOp;
   logic       pcWriteRaw;
   logic       memWriteRaw;
   logic       irWriteRaw;
   logic       regWriteRaw;
   logic       branchTaken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= stateT'(RESET_STATE);
         illegalOp <= 1'b0;
      end else begin
         illegalOp <= 1'b0;
         case (state)
            FETCH:    if (mem_ready) state <= DECODE;
            DECODE: begin
               case (op)
                  OP_LOAD, OP_STORE: state <= MEMADR;
                  OP_RTYPE:          state <= EXECR;
                  OP_ITYPE:          state <= EXECI;
                  OP_BRANCH:         state <= BRANCH;
                  OP_JAL:            state <= JAL;
                  OP_LUI:            state <= LUI;
                  OP_AUIPC:          state <= AUIPC;
                  default: begin
                     state     <= FETCH;
                     illegalOp <= 1'b1;
                  end
               endcase
            end
            MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state <= MEMWB;
            MEMWB:    state <= FETCH;
            MEMWRITE: if (mem_ready) state <= FETCH;
            EXECR:    state <= ALUWB;
            EXECI:    state <= ALUWB;
            ALUWB:    state <= FETCH;
            BRANCH:   state <= FETCH;
            JAL:      state <= ALUWB;
            LUI:      state <= ALUWB;
            AUIPC:    state <= ALUWB;
            default:  state <= FETCH;
         endcase
      end
   end

   // Only beq/bne are supported; any other branch funct3 never redirects the PC.
   assign branchTaken = (funct3[2:1] == 2'b00) ? (zero ^ funct3[0]) : 1'b0;

   always_comb begin
      pcWriteRaw  = 1'b0;
      adr_src     = 1'b0;
      memWriteRaw = 1'b0;
      irWriteRaw  = 1'b0;
      regWriteRaw = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_B;
      aluOp       = ALUOP_ADD;
      case (state)
         FETCH: begin
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            irWriteRaw = mem_ready;
            pcWriteRaw = mem_ready;
         end
         DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         MEMADR: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
         end
         MEMREAD:  adr_src = 1'b1;
         MEMWB: begin
            result_src  = RES_DATA;
            regWriteRaw = 1'b1;
         end
         MEMWRITE: begin
            adr_src     = 1'b1;
            memWriteRaw = 1'b1;
         end
         EXECR: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_B;
            aluOp     = ALUOP_FUNCT;
         end
         EXECI: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
            aluOp     = ALUOP_FUNCT;
         end
         ALUWB: begin
            result_src  = RES_ALUOUT;
            regWriteRaw = 1'b1;
         end
         BRANCH: begin
            alu_src_a  = SRCA_A;
            alu_src_b  = SRCB_B;
            aluOp      = ALUOP_SUB;
            result_src = RES_ALUOUT;
            pcWriteRaw = branchTaken;
         end
         JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALUOUT;
            pcWriteRaw = 1'b1;
         end
         LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
         end
         AUIPC: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         default: ;
      endcase
   end

   // Strobes are gated by rst_n so no partial write completes while reset is held.
   assign pc_write   = pcWriteRaw & rst_n;
   assign mem_write  = memWriteRaw & rst_n;
   assign ir_write   = irWriteRaw & rst_n;
   assign reg_write  = regWriteRaw & rst_n;
   assign imm_src    = immSrcFor(op);
   assign illegal_op = illegalOp;
   assign state_dbg  = state;

   alu_decoder uAluDecoder (
      .aluOp      (aluOp),
      .funct3     (funct3),
      .op5        (op[5]),
      .funct7b5   (funct7b5),
      .aluControl (alu_control)
   );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM controller that sequences a shared-memory, multi-cycle RV32I datapath (PC, IR, OldPC, A/B, ALUOut and Data registers, one ALU, one memory port).
- Decodes op/funct3/funct7b5 and drives per-cycle mux selects and write strobes.
- Replaces the single-cycle main decoder when the core moves to a unified instruction/data memory.
- Memory accesses use a ready handshake so the memory may stall.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); fixed encoding from the shared package.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag (combinational, same cycle)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load strobe
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  IR and OldPC load strobe
- reg_write  out  1  register-file write strobe
- result_src  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  SrcA mux: 00=PC, 01=OldPC, 10=A, 11=zero
- alu_src_b  out  2  SrcB mux: 00=B, 01=ImmExt, 10=4
- imm_src  out  3  immediate format: 000=I, 001=S, 010=B, 011=J, 100=U
- alu_control  out  3  000=add, 001=sub, 010=and, 011=or, 101=slt
- illegal_op  out  1  registered one-cycle pulse on an undecodable opcode
- state_dbg  out  4  current state

Behaviour:
- Async reset: state=FETCH, illegal_op=0.
- While rst_n=0, pc_write, ir_write, reg_write and mem_write are forced to 0.
- Outputs are combinational from the state; imm_src and alu_control are also functions of op/funct3.
- Unlisted outputs are 0 in every state.
- States and their outputs/transitions:
  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_write = mem_ready. Stay in FETCH while !mem_ready, else go to DECODE.
  - DECODE: a=01, b=01, alu_op=00 (computes branch target). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other op -> FETCH, with illegal_op=1 on the next cycle only.
  - MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1. Go to FETCH.
  - MEMWRITE: adr_src=1, mem_write=1 held until mem_ready, then go to FETCH.
  - EXECR: a=10, b=00, alu_op=10. Go to ALUWB.
  - EXECI: a=10, b=01, alu_op=10. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Go to FETCH.
  - BRANCH: a=10, b=00, alu_op=01, result_src=00. Go to FETCH.
    - pc_write = zero XOR funct3[0] (beq: funct3=000, bne: funct3=001).
    - Other funct3 values: pc_write=0.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB.
  - LUI: a=11, b=01, alu_op=00. Go to ALUWB.
  - AUIPC: a=01, b=01, alu_op=00. Go to ALUWB.
- Undefined state encodings go to FETCH.
- imm_src by op: 0100011 -> S, 1100011 -> B, 1101111 -> J, 0110111 or 0010111 -> U, all others -> I.
- alu_control:
  - alu_op=00 -> add; alu_op=01 -> sub.
  - alu_op=10, decoded by funct3:
    - 000 -> sub if op[5]&funct7b5, else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other funct3 -> add
- Latency in cycles, with mem_ready=1: lw 5, sw 4, R/I 4, branch 3, jal 4, lui/auipc 4. Each mem_ready=0 cycle adds one.
- Reset mid-instruction: state returns to FETCH immediately. Strobes are deasserted asynchronously and no partial write completes.

Decomposition:
- Package multicycle_pkg holds:
  - state enum (FETCH=0 .. AUIPC=12)
  - opcode constants
  - ALU-op, result_src, alu_src_a/b, imm_src and alu_control encodings.
- Sub-module alu_decoder (alu_op, funct3, op5, funct7b5 -> alu_control) is purely combinational and instantiated once.

Test Plan:
- Reset: rst_n=0 mid-EXECR -> state_dbg=0 same cycle, all strobes 0; release -> FETCH with ir_write=pc_write=mem_ready.
- lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4; MEMWB has result_src=01, reg_write=1, imm_src=000.
- sw (op=0100011), mem_ready low 3 cycles in MEMWRITE -> mem_write=1 and adr_src=1 for 4 cycles, then FETCH; imm_src=001, reg_write never 1.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> EXECR alu_control=001, ALUWB reg_write=1. Same with funct3=110 -> alu_control=011.
- beq with zero=1 -> BRANCH pc_write=1. With zero=0 -> 0. bne (funct3=001) with zero=0 -> pc_write=1.
- jal / lui / auipc -> JAL pc_write=1, imm_src=011; LUI a=11; AUIPC a=01, imm_src=100. op=0000000 -> DECODE->FETCH, illegal_op high exactly 1 cycle.
